dtw_accel_m00_axi: RTL and testbench

// AXI4-Lite initiator issuing single, non-overlapping read/write transactions from a valid/ready

---
 rtl/dtw_accel_m00_axi_pkg.sv | 36 +++
 rtl/dtw_accel_m00_axi_if.sv | 43 ++++
 rtl/dtw_accel_m00_axi.sv | 229 ++++++++++++++++++++++
 tb/tb_dtw_accel_m00_axi.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_accel_m00_axi_pkg.sv
// Shared definitions for the DTW accelerator AXI4-Lite initiator.
//   - AXI response codes (OKAY/EXOKAY/SLVERR/DECERR)
//   - DTW register slave offsets (CR, SR, REF_LEN)
//   - Initiator FSM state enum and a helper that flags the states
//     in which the initiator is waiting on an AXI handshake.
package dtw_accel_m00_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [7:0] REG_CR_OFS      = 8'h00;
    localparam logic [7:0] REG_SR_OFS      = 8'h04;
    localparam logic [7:0] REG_REF_LEN_OFS = 8'h08;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_BRESP = 3'd2,
        ST_RD    = 3'd3,
        ST_RDATA = 3'd4,
        ST_RSP   = 3'd5
    } axi_state_e;

    // States in which the timeout counter runs.
    function automatic logic is_wait_state(input axi_state_e s);
        logic w;
        case (s)
            ST_WR, ST_BRESP, ST_RD, ST_RDATA: w = 1'b1;
            default:                          w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dtw_accel_m00_axi_if.sv
// AXI4-Lite bus bundle between the DTW initiator and a register slave.
// Parameters: DW data width, AW address width.
// Modports: master (initiator side), slave (target side).
interface dtw_accel_m00_axi_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );
endinterface

// File: rtl/dtw_accel_m00_axi.sv
// AXI4-Lite initiator: accepts one read/write command at a time on a
// valid/ready command port, runs it on the AXI bus and returns the result
// on a valid/ready response port. All bus outputs come from registers.
// Ports:
//   M_AXI_ACLK / M_AXI_ARESET : clock, synchronous active-high reset
//   cmd_*                     : command (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                     : response (valid/ready, write, rdata, resp)
//   timeout_err               : sticky flag, a handshake waited C_TIMEOUT_CYCLES
//   m_axi                     : AXI4-Lite master bundle
module dtw_accel_m00_axi
    import dtw_accel_m00_axi_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 5,
    parameter int C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              timeout_err,
    dtw_accel_m00_axi_if.master               m_axi
);

    localparam int DW    = C_M_AXI_DATA_WIDTH;
    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int TMO_W = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(C_TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
    localparam bit               TMO_EN    = (C_TIMEOUT_CYCLES != 0);

    axi_state_e      state_q,     state_d;
    logic            awvalid_q,   awvalid_d;
    logic            wvalid_q,    wvalid_d;
    logic            bready_q,    bready_d;
    logic            arvalid_q,   arvalid_d;
    logic            rready_q,    rready_d;
    logic [AW-1:0]   addr_q,      addr_d;
    logic [DW-1:0]   wdata_q,     wdata_d;
    logic [DW/8-1:0] wstrb_q,     wstrb_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_write_q, rsp_write_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_resp_q,  rsp_resp_d;
    logic [TMO_W-1:0] tmo_cnt_q,  tmo_cnt_d;
    logic            tmo_err_q,   tmo_err_d;

    // Next-state, bus-control and response-capture logic
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        tmo_cnt_d   = tmo_cnt_q;
        tmo_err_d   = tmo_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD;
                        arvalid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                // AW and W complete independently; each VALID drops once its READY is seen.
                awvalid_d = awvalid_q & ~m_axi.awready;
                wvalid_d  = wvalid_q  & ~m_axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_BRESP;
                    bready_d = 1'b1;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_BRESP: begin
                if (m_axi.bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axi.bresp;
                    state_d     = ST_RSP;
                end else begin
                    state_d = ST_BRESP;
                end
            end
            ST_RD: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RDATA;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_RDATA: begin
                if (m_axi.rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_axi.rdata;
                    rsp_resp_d  = m_axi.rresp;
                    state_d     = ST_RSP;
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        // Timeout counter restarts on every state change and saturates at the limit;
        // the flag only reports, the transaction keeps waiting.
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if (TMO_EN && is_wait_state(state_q) && (tmo_cnt_q != TMO_LIMIT)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end

        if (TMO_EN && is_wait_state(state_q) && (tmo_cnt_d == TMO_LIMIT)) begin
            tmo_err_d = 1'b1;
        end else begin
            tmo_err_d = tmo_err_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q     <= ST_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            tmo_cnt_q   <= '0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign cmd_ready     = (state_q == ST_IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign timeout_err   = tmo_err_q;

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_dtw_accel_m00_axi.sv
// Bench for dtw_accel_m00_axi: a behavioural DTW register slave with
// per-channel stall knobs, a response scoreboard and directed steps.
module tb_dtw_accel_m00_axi;
    import dtw_accel_m00_axi_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int TMO   = 16;
    localparam int BOUND = 200;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          cmd_ready;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          timeout_err;

    dtw_accel_m00_axi_if #(.DW(DW), .AW(AW)) axi ();

    dtw_accel_m00_axi #(
        .C_M_AXI_DATA_WIDTH(DW),
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_TIMEOUT_CYCLES  (TMO)
    ) dut (
        .M_AXI_ACLK  (clk),
        .M_AXI_ARESET(rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .timeout_err (timeout_err),
        .m_axi       (axi)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard and counters ----------------
    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb[$];

    int n_assert  = 0;
    int n_fail    = 0;
    int n_wr_sent = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // ---------------- behavioural DTW register slave ----------------
    int            aw_lat = 0, w_lat = 0;
    bit            b_never = 1'b0;
    int            aw_cnt = 0, w_cnt = 0;
    bit            aw_got = 1'b0, w_got = 1'b0;
    logic [AW-1:0] aw_addr_l = '0;
    logic [AW-1:0] last_araddr = '0;
    logic [31:0]   w_data_l = '0;
    logic [3:0]    w_strb_l = '0;
    logic [31:0]   cr_r = '0, sr_r = '0, rl_r = 32'd29898;
    int            n_aw_hs = 0, n_w_hs = 0, n_commit = 0;

    always @(posedge clk) begin
        if (rst) begin
            axi.awready <= 1'b0; axi.wready <= 1'b0; axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
            axi.arready <= 1'b0; axi.rvalid <= 1'b0; axi.rdata <= '0;    axi.rresp <= 2'b00;
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            cr_r <= '0; sr_r <= '0; rl_r <= 32'd29898;
        end else begin
            if (axi.awvalid && axi.awready) begin
                axi.awready <= 1'b0; aw_got <= 1'b1; aw_addr_l <= axi.awaddr;
                aw_cnt <= 0; n_aw_hs <= n_aw_hs + 1;
            end else if (axi.awvalid && !aw_got) begin
                if (aw_cnt >= aw_lat) axi.awready <= 1'b1;
                else aw_cnt <= aw_cnt + 1;
            end
            if (axi.wvalid && axi.wready) begin
                axi.wready <= 1'b0; w_got <= 1'b1; w_data_l <= axi.wdata; w_strb_l <= axi.wstrb;
                w_cnt <= 0; n_w_hs <= n_w_hs + 1;
            end else if (axi.wvalid && !w_got) begin
                if (w_cnt >= w_lat) axi.wready <= 1'b1;
                else w_cnt <= w_cnt + 1;
            end
            if (aw_got && w_got) begin
                aw_got <= 1'b0; w_got <= 1'b0; n_commit <= n_commit + 1;
                axi.bvalid <= !b_never;
                axi.bresp  <= aw_addr_l[4] ? RESP_SLVERR : RESP_OKAY;
                if (!aw_addr_l[4]) begin
                    case (aw_addr_l[3:2])
                        2'd0:    cr_r <= merge(cr_r, w_data_l, w_strb_l);
                        2'd2:    rl_r <= merge(rl_r, w_data_l, w_strb_l);
                        default: ;
                    endcase
                end
            end
            if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
            if (axi.arvalid && axi.arready) begin
                axi.arready <= 1'b0; axi.rvalid <= 1'b1; last_araddr <= axi.araddr;
                if (axi.araddr[4]) begin
                    axi.rdata <= '0; axi.rresp <= RESP_SLVERR;
                end else begin
                    axi.rresp <= RESP_OKAY;
                    case (axi.araddr[3:2])
                        2'd0:    axi.rdata <= cr_r;
                        2'd1:    axi.rdata <= sr_r;
                        2'd2:    axi.rdata <= rl_r;
                        default: axi.rdata <= '0;
                    endcase
                end
            end else if (axi.arvalid) begin
                axi.arready <= 1'b1;
            end
            if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
        end
    end

    // ---------------- VALID / payload stability monitor ----------------
    logic          p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
    logic [AW-1:0] p_awa = '0, p_ara = '0;
    logic [31:0]   p_wd = '0;
    logic [3:0]    p_ws = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (p_awv && !p_awr) check("aw_stable", {axi.awvalid, axi.awaddr}, {1'b1, p_awa});
            if (p_wv && !p_wr)   check("w_stable", {axi.wvalid, axi.wdata, axi.wstrb}, {1'b1, p_wd, p_ws});
            if (p_arv && !p_arr) check("ar_stable", {axi.arvalid, axi.araddr}, {1'b1, p_ara});
        end
        p_awv <= axi.awvalid; p_awr <= axi.awready; p_awa <= axi.awaddr;
        p_wv  <= axi.wvalid;  p_wr  <= axi.wready;  p_wd  <= axi.wdata; p_ws <= axi.wstrb;
        p_arv <= axi.arvalid; p_arr <= axi.arready; p_ara <= axi.araddr;
    end

    // ---------------- stimulus helpers (start and end on a negedge) ----------------
    task automatic present_cmd(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [31:0] er, input logic [1:0] eresp);
        exp_t e;
        e.wr = wr; e.rdata = wr ? 32'h0 : er; e.resp = eresp;
        sb.push_back(e);
        if (wr) n_wr_sent++;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    endtask

    task automatic wait_accept();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_accepted", ok, 1'b1);
    endtask

    task automatic wait_rsp(input int hold);
        logic        ok;
        logic [34:0] snap;
        exp_t        e;
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("rsp_seen", ok, 1'b1);
        if (!ok) return;
        snap = {rsp_write, rsp_rdata, rsp_resp};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rsp_hold_stable", {rsp_valid, rsp_write, rsp_rdata, rsp_resp}, {1'b1, snap});
            check("cmd_ready_low_in_rsp", cmd_ready, 1'b0);
        end
        check("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_fields", {rsp_write, rsp_rdata, rsp_resp}, {e.wr, e.rdata, e.resp});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 1'b0);
    endtask

    task automatic do_cmd(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] er, input logic [1:0] eresp);
        present_cmd(wr, a, d, s, er, eresp);
        wait_accept();
        wait_rsp(0);
    endtask

    task automatic check_wr_counts(input string tag);
        check({tag, "_commits"}, 64'(n_commit), 64'(n_wr_sent));
        check({tag, "_aw_hs"},   64'(n_aw_hs),  64'(n_wr_sent));
        check({tag, "_w_hs"},    64'(n_w_hs),   64'(n_wr_sent));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                              rsp_valid, timeout_err}, 7'b0);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, "_regs"}, {axi.awaddr, axi.wdata, axi.wstrb, rsp_write, rsp_rdata, rsp_resp},
              64'd0);
        check({tag, "_prot"}, {axi.awprot, axi.arprot}, 6'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic ok;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // reset values of the register slave, then basic write/readback
        do_cmd(1'b0, 5'h08, 32'h0, 4'h0, 32'h0000_74CA, RESP_OKAY);
        do_cmd(1'b0, 5'h0C, 32'h0, 4'h0, 32'h0000_0000, RESP_OKAY);
        do_cmd(1'b1, 5'h08, 32'h0000_1234, 4'hF, 32'h0, RESP_OKAY);
        do_cmd(1'b0, 5'h08, 32'h0, 4'h0, 32'h0000_1234, RESP_OKAY);
        do_cmd(1'b1, 5'h00, 32'hAABB_CCDD, 4'h3, 32'h0, RESP_OKAY);
        do_cmd(1'b0, 5'h00, 32'h0, 4'h0, 32'h0000_CCDD, RESP_OKAY);

        // AW/W handshake ordering: AW first, W first, same cycle
        aw_lat = 0; w_lat = 3;
        do_cmd(1'b1, 5'h00, 32'h1111_1111, 4'hF, 32'h0, RESP_OKAY);
        check_wr_counts("aw_first");
        aw_lat = 3; w_lat = 0;
        do_cmd(1'b1, 5'h08, 32'h2222_2222, 4'hF, 32'h0, RESP_OKAY);
        check_wr_counts("w_first");
        aw_lat = 2; w_lat = 2;
        do_cmd(1'b1, 5'h00, 32'h3333_3333, 4'hC, 32'h0, RESP_OKAY);
        check_wr_counts("same_cycle");
        aw_lat = 0; w_lat = 0;
        do_cmd(1'b0, 5'h00, 32'h0, 4'h0, 32'h3333_1111, RESP_OKAY);
        do_cmd(1'b0, 5'h08, 32'h0, 4'h0, 32'h2222_2222, RESP_OKAY);

        // error responses pass through; unaligned address goes out unchanged
        do_cmd(1'b1, 5'h10, 32'h0000_DEAD, 4'hF, 32'h0, RESP_SLVERR);
        do_cmd(1'b0, 5'h10, 32'h0, 4'h0, 32'h0, RESP_SLVERR);
        do_cmd(1'b0, 5'h0D, 32'h0, 4'h0, 32'h0, RESP_OKAY);
        check("unaligned_araddr", last_araddr, 5'h0D);

        // response back-pressure with a second command already waiting
        present_cmd(1'b0, 5'h08, 32'h0, 4'h0, 32'h2222_2222, RESP_OKAY);
        wait_accept();
        present_cmd(1'b0, 5'h00, 32'h0, 4'h0, 32'h3333_1111, RESP_OKAY);
        wait_rsp(10);
        wait_accept();
        wait_rsp(0);

        // write response never arrives: timeout flag at the 16th wait cycle
        check("tmo_clear_before", timeout_err, 1'b0);
        b_never = 1'b1;
        present_cmd(1'b1, 5'h00, 32'h0000_0055, 4'hF, 32'h0, RESP_OKAY);
        wait_accept();
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            if (axi.bready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("bready_seen", ok, 1'b1);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_not_yet", timeout_err, 1'b0);
        @(negedge clk);
        check("tmo_set", timeout_err, 1'b1);
        repeat (5) @(negedge clk);
        check("tmo_still_waiting", {timeout_err, axi.bready, rsp_valid, cmd_ready}, 4'b1100);

        // reset mid-wait drops everything; next command completes normally
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b0;
        b_never = 1'b0;
        sb.delete();
        do_cmd(1'b0, 5'h08, 32'h0, 4'h0, 32'h0000_74CA, RESP_OKAY);
        check("tmo_after_reset", timeout_err, 1'b0);
        check("sb_drained", sb.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
